// File: rtl/button_counter.sv
// Three-button up/down/clear counter: each raw button is synchronized and
// debounced, and accepted presses update an 8-bit count shown on LED.
module button_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_CLR,
    output logic [7:0] LED,
    output logic       PRESS_EVT
);

    localparam int unsigned NBTN    = 3;
    localparam int unsigned IDX_UP  = 0;
    localparam int unsigned IDX_DN  = 1;
    localparam int unsigned IDX_CLR = 2;
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0]  btn_raw;
    logic [NBTN-1:0]  sync_q1;
    logic [NBTN-1:0]  sync_q2;
    logic [NBTN-1:0]  stable;
    logic [NBTN-1:0]  stable_d;
    logic [NBTN-1:0]  press;
    logic [NBTN-1:0]  differ_c;
    logic [CNT_W-1:0] cnt [NBTN];

    assign btn_raw  = {BTN_CLR, BTN_DOWN, BTN_UP};
    assign differ_c = sync_q2 ^ stable;

    // Two-flop synchronizers for the asynchronous buttons
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Debouncers: a differing level must persist DEBOUNCE_CYCLES samples to flip
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            stable <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NBTN); i++) begin
                if (!differ_c[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level is a press; release is ignored
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            stable_d <= '0;
            press    <= '0;
        end else begin
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

    // Count update: clear wins, simultaneous up+down cancel
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            LED       <= '0;
            PRESS_EVT <= 1'b0;
        end else begin
            PRESS_EVT <= 1'b0;
            if (press[IDX_CLR]) begin
                LED       <= '0;
                PRESS_EVT <= 1'b1;
            end else if (press[IDX_UP] != press[IDX_DN]) begin
                LED       <= press[IDX_UP] ? LED + 8'd1 : LED - 8'd1;
                PRESS_EVT <= 1'b1;
            end
        end
    end

endmodule

// File: doc/button_counter.md
BUTTON_COUNTER -- requirements
Module: button_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000; cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 CLK_IN  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 BTN_UP  input  1  raw push button, active-high, asynchronous to CLK_IN, bouncy; press increments the count.
REQ-005 BTN_DOWN  input  1  raw push button, active-high, asynchronous, bouncy; press decrements the count.
REQ-006 BTN_CLR  input  1  raw push button, active-high, asynchronous, bouncy; press clears the count.
REQ-007 LED  output  8  current count value, registered.
REQ-008 PRESS_EVT  output  1  one-cycle pulse on every clock edge where LED is updated by an accepted press.

Function
REQ-009 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-010 Each button SHALL have an independent debouncer: a stable-level register plus a counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-011 Debouncer behaviour: while the synchronized level equals the stable level, the counter SHALL hold 0. While it differs, the counter SHALL increment by 1 per cycle.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the stable level SHALL flip and the counter SHALL return to 0 on the same edge.
REQ-013 Any sample equal to the stable level SHALL restart the count at 0. Glitches shorter than DEBOUNCE_CYCLES never change the stable level.
REQ-014 A stable-level 0->1 transition SHALL produce a one-cycle press pulse, registered one edge after the flip. A 1->0 transition (release) SHALL produce nothing.
REQ-015 Count update is one edge after the press pulse. For a clean input rising before edge 0 and held, LED SHALL change on edge DEBOUNCE_CYCLES+3, with PRESS_EVT high for that one cycle.
REQ-016 Count update rules, in priority order:
  - CLR pulse: count <= 0.
  - UP and DOWN pulses on the same cycle: no change, and PRESS_EVT SHALL stay 0.
  - UP pulse alone: count <= count+1 mod 256 (255 -> 0).
  - DOWN pulse alone: count <= count-1 mod 256 (0 -> 255).
REQ-017 CLR with UP and/or DOWN on the same cycle SHALL give 0 with PRESS_EVT=1. CLR when the count is already 0 SHALL still pulse PRESS_EVT.
REQ-018 Holding a button SHALL yield exactly one press; there is no auto-repeat. A new press requires a debounced release first.
REQ-019 LED and PRESS_EVT SHALL be driven directly from flops.

Reset
REQ-020 RST_N low SHALL immediately, without a clock, force:
  - LED = 0 and PRESS_EVT = 0;
  - all synchronizer flops, stable levels and debounce counters = 0;
  - all internal press pulses = 0.
REQ-021 Reset asserted mid-debounce SHALL discard the partial count. A button still held at deassertion SHALL be accepted as a new press after the full REQ-015 latency.
REQ-022 Deassertion SHALL be synchronized externally. The block SHALL need no clock edge during reset.

Verification (DEBOUNCE_CYCLES=4)
REQ-023 BTN_UP held high from edge 0 -> LED 0x00->0x01 at edge 7, PRESS_EVT high for exactly that cycle, no further change while held.
REQ-024 BTN_UP toggling every 2 cycles for 40 cycles, then low -> LED stays 0x00, PRESS_EVT never asserts.
REQ-025 LED=0x00, one DOWN press -> 0xFF. Then 256 UP presses -> LED returns to 0xFF, having passed through 0x00 at press 1.
REQ-026 UP and DOWN rising on the same edge, both held -> LED unchanged, PRESS_EVT 0. With CLR also rising together -> LED=0x00, PRESS_EVT pulses once.
REQ-027 LED=0x05, RST_N low for 1 ns between edges while BTN_UP debounce counter=2 -> LED=0x00 immediately. With BTN_UP still held, LED=0x01 at edge 7 after the first edge following release of RST_N.
REQ-028 Press, release, press UP with each phase held 6 cycles -> exactly two increments, each PRESS_EVT pulse exactly 1 cycle wide.
